// File: rtl/decode_queue.sv
// RV32I decode queue: instructions are decoded at enqueue and held in a small
// FIFO so the consumer sees fully decoded control one cycle after acceptance.

package decode_queue_pkg;

    typedef logic [31:0] instruction_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        op_a_pc;
        logic        op_b_imm;
        logic        regfile_we;
        logic        csr_we;
        logic        dcache_rd_enable;
        logic        dcache_wr_enable;
        logic        is_branch;
        logic        is_jump;
        logic        is_ecall;
        logic        is_mem_access;
        logic        is_csr;
        logic        is_fence;
    } decode_out_t;

    typedef struct packed {
        decode_out_t  dec;
        instruction_t instr;
        logic [31:0]  pc;
        logic         illegal;
        logic         ebreak;
    } entry_t;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  instruction_t               instr_i,
    input  logic [31:0]                pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output decode_out_t                decode_o,
    output instruction_t               instr_o,
    output logic [31:0]                pc_o,
    output logic                       illegal_o,
    output logic                       ebreak_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];

    logic          push_s;
    logic          pop_s;
    entry_t        enq_s;
    entry_t        head_s;

    decode_out_t   dec_s;
    logic          ill_raw_s;
    logic          illegal_s;
    logic          ebreak_s;

    logic [6:0]    opcode_s;
    logic [2:0]    f3_s;
    logic [6:0]    f7_s;
    logic [31:0]   imm_i_s;
    logic [31:0]   imm_s_s;
    logic [31:0]   imm_b_s;
    logic [31:0]   imm_u_s;
    logic [31:0]   imm_j_s;

    assign opcode_s = instr_i[6:0];
    assign f3_s     = instr_i[14:12];
    assign f7_s     = instr_i[31:25];
    assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_s  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_s  = {instr_i[31:12], 12'h000};
    assign imm_j_s  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Field decode of the offered instruction plus raw illegal-encoding detection
    always_comb begin
        dec_s        = '0;
        ill_raw_s    = 1'b0;
        ebreak_s     = 1'b0;
        dec_s.rd     = instr_i[11:7];
        dec_s.rs1    = instr_i[19:15];
        dec_s.rs2    = instr_i[24:20];
        dec_s.funct3 = f3_s;
        dec_s.alu_op = ALU_ADD;
        case (opcode_s)
            OPC_LUI: begin
                dec_s.imm        = imm_u_s;
                dec_s.op_b_imm   = 1'b1;
                dec_s.alu_op     = ALU_PASS_B;
                dec_s.regfile_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.imm        = imm_u_s;
                dec_s.op_a_pc    = 1'b1;
                dec_s.op_b_imm   = 1'b1;
                dec_s.regfile_we = 1'b1;
            end
            OPC_JAL: begin
                dec_s.imm        = imm_j_s;
                dec_s.op_a_pc    = 1'b1;
                dec_s.op_b_imm   = 1'b1;
                dec_s.is_jump    = 1'b1;
                dec_s.regfile_we = 1'b1;
            end
            OPC_JALR: begin
                dec_s.imm        = imm_i_s;
                dec_s.op_b_imm   = 1'b1;
                dec_s.is_jump    = 1'b1;
                dec_s.regfile_we = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.imm       = imm_b_s;
                dec_s.is_branch = 1'b1;
                case (f3_s[2:1])
                    2'b00:   dec_s.alu_op = ALU_SUB;
                    2'b10:   dec_s.alu_op = ALU_SLT;
                    2'b11:   dec_s.alu_op = ALU_SLTU;
                    default: ill_raw_s    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_s.imm              = imm_i_s;
                dec_s.op_b_imm         = 1'b1;
                dec_s.regfile_we       = 1'b1;
                dec_s.dcache_rd_enable = 1'b1;
                dec_s.is_mem_access    = 1'b1;
                ill_raw_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
            end
            OPC_STORE: begin
                dec_s.imm              = imm_s_s;
                dec_s.op_b_imm         = 1'b1;
                dec_s.dcache_wr_enable = 1'b1;
                dec_s.is_mem_access    = 1'b1;
                ill_raw_s = (f3_s > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_s.imm        = imm_i_s;
                dec_s.op_b_imm   = 1'b1;
                dec_s.regfile_we = 1'b1;
                case (f3_s)
                    3'b000: dec_s.alu_op = ALU_ADD;
                    3'b001: begin
                        dec_s.alu_op = ALU_SLL;
                        ill_raw_s    = (f7_s != 7'h00);
                    end
                    3'b010: dec_s.alu_op = ALU_SLT;
                    3'b011: dec_s.alu_op = ALU_SLTU;
                    3'b100: dec_s.alu_op = ALU_XOR;
                    3'b101: begin
                        dec_s.alu_op = (f7_s == 7'h20) ? ALU_SRA : ALU_SRL;
                        ill_raw_s    = (f7_s != 7'h00) && (f7_s != 7'h20);
                    end
                    3'b110: dec_s.alu_op = ALU_OR;
                    3'b111: dec_s.alu_op = ALU_AND;
                    default: dec_s.alu_op = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                dec_s.regfile_we = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.alu_op = f7_s[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_s.alu_op = ALU_SLL;
                    3'b010:  dec_s.alu_op = ALU_SLT;
                    3'b011:  dec_s.alu_op = ALU_SLTU;
                    3'b100:  dec_s.alu_op = ALU_XOR;
                    3'b101:  dec_s.alu_op = f7_s[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_s.alu_op = ALU_OR;
                    3'b111:  dec_s.alu_op = ALU_AND;
                    default: dec_s.alu_op = ALU_ADD;
                endcase
                if ((f7_s != 7'h00) && (f7_s != 7'h20)) begin
                    ill_raw_s = 1'b1;
                end else if ((f7_s == 7'h20) && (f3_s != 3'b000) && (f3_s != 3'b101)) begin
                    ill_raw_s = 1'b1;
                end else begin
                    ill_raw_s = 1'b0;
                end
            end
            OPC_MISC_MEM: begin
                dec_s.is_fence = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_s.imm = {20'h00000, instr_i[31:20]};
                if (f3_s == 3'b000) begin
                    if (instr_i[31:20] == 12'h000) begin
                        dec_s.is_ecall = 1'b1;
                    end else if (instr_i[31:20] == 12'h001) begin
                        ebreak_s = 1'b1;
                    end else begin
                        ill_raw_s = 1'b1;
                    end
                end else if (f3_s == 3'b100) begin
                    ill_raw_s = 1'b1;
                end else begin
                    // CSRRS/CSRRC with rs1=x0 are pure reads and must not write the CSR
                    dec_s.is_csr     = 1'b1;
                    dec_s.regfile_we = 1'b1;
                    dec_s.op_b_imm   = f3_s[2];
                    dec_s.csr_we     = !(f3_s[1] && (instr_i[19:15] == 5'd0));
                end
            end
            default: ill_raw_s = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) begin
            ill_raw_s = 1'b1;
        end else begin
            ill_raw_s = ill_raw_s;
        end
    end

    // Illegal entries carry no architectural side effects
    always_comb begin
        enq_s         = '0;
        illegal_s     = (CHECK_ILLEGAL != 0) ? ill_raw_s : 1'b0;
        enq_s.dec     = dec_s;
        enq_s.instr   = instr_i;
        enq_s.pc      = pc_i;
        enq_s.illegal = illegal_s;
        enq_s.ebreak  = ebreak_s;
        if (illegal_s) begin
            enq_s.dec.regfile_we       = 1'b0;
            enq_s.dec.csr_we           = 1'b0;
            enq_s.dec.dcache_wr_enable = 1'b0;
            enq_s.dec.is_branch        = 1'b0;
            enq_s.dec.is_jump          = 1'b0;
            enq_s.dec.is_ecall         = 1'b0;
            enq_s.dec.is_mem_access    = 1'b0;
        end else begin
            enq_s.dec = dec_s;
        end
    end

    assign in_ready_o  = (count_q < CW'(DEPTH));
    assign out_valid_o = (count_q != {CW{1'b0}});
    assign push_s      = in_valid_i && in_ready_o && !flush_i;
    assign pop_s       = out_valid_o && out_ready_i && !flush_i;

    // Pointer and occupancy next state; flush wins over any transfer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= enq_s;
        end
    end

    // Head entry, forced to zero whenever the queue is empty
    always_comb begin
        head_s = '0;
        if (out_valid_o) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign decode_o  = head_s.dec;
    assign instr_o   = head_s.instr;
    assign pc_o      = head_s.pc;
    assign illegal_o = head_s.illegal;
    assign ebreak_o  = head_s.ebreak;
    assign count_o   = count_q;

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of decoded-instruction entries (power of two, >=2).
REQ-002 SHALL have parameter CHECK_ILLEGAL, default 1, meaning illegal-encoding detection is enabled (0 = every entry reports legal).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all entries.
REQ-006 SHALL have port in_valid_i, input, 1 bit: fetch offers an instruction.
REQ-007 SHALL have port in_ready_o, output, 1 bit: queue accepts the instruction.
REQ-008 SHALL have port instr_i, input, instruction_t (32): raw instruction.
REQ-009 SHALL have port pc_i, input, 32 bits: PC of instr_i.
REQ-010 SHALL have port out_valid_o, output, 1 bit: head entry is valid.
REQ-011 SHALL have port out_ready_i, input, 1 bit: consumer takes the head entry.
REQ-012 SHALL have port decode_o, output, decode_out_t: decoded control of the head entry.
REQ-013 SHALL have port instr_o, output, instruction_t: raw instruction of the head entry.
REQ-014 SHALL have port pc_o, output, 32 bits: PC of the head entry.
REQ-015 SHALL have port illegal_o, output, 1 bit: head entry is an illegal encoding.
REQ-016 SHALL have port ebreak_o, output, 1 bit: head entry is EBREAK.
REQ-017 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-018 SHALL decode instr_i combinationally at enqueue into decode_out_t with the standard RV32I field mapping (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM/CSR), and store the decoded word, instr_i, pc_i and flags in the entry.
REQ-019 SHALL enqueue when in_valid_i && in_ready_o && !flush_i; in_ready_o = (count_o < DEPTH), with no same-cycle dequeue credit.
REQ-020 SHALL dequeue when out_valid_o && out_ready_i && !flush_i; out_valid_o = (count_o != 0).
REQ-021 SHALL present an enqueued entry at the outputs the cycle after acceptance (latency 1, no bypass).
REQ-022 SHALL apply simultaneous enqueue and dequeue in the same cycle, leaving count_o unchanged.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL, when CHECK_ILLEGAL=1, flag illegal for: unknown opcode; instr[1:0]!=2'b11; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 >010; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101; SLLI with imm[11:5]!=0; SRLI/SRAI with imm[11:5] not 0x00/0x20; SYSTEM funct3 100; PRIV with imm not ECALL/EBREAK.
REQ-025 SHALL force regfile_we, csr_we, dcache_wr_enable, is_branch, is_jump, is_ecall and is_mem_access to 0 in any entry flagged illegal.
REQ-026 SHALL set ebreak_o for SYSTEM, funct3 000, imm 0x001; is_ecall for imm 0x000.
REQ-027 SHALL, on flush_i, set count_o=0 and both pointers to 0 at the next edge; any enqueue or dequeue in that cycle is discarded.
REQ-028 SHALL hold the head entry outputs stable while out_valid_o && !out_ready_i.
REQ-029 SHALL drive decode_o, instr_o, pc_o, illegal_o and ebreak_o as don't-care-free zeros when out_valid_o=0.

Reset
REQ-030 SHALL, while reset_i=1, asynchronously force count_o=0, pointers=0, out_valid_o=0, in_ready_o=1, and all entry outputs to 0.
REQ-031 SHALL discard in-flight entries on reset mid-operation; the first edge after deassertion behaves as from empty.

Verification
REQ-032 SHALL pass: enqueue 0x00500093 (ADDI x1,x0,5) at pc 0x100 -> next cycle out_valid_o=1, alu_op=ADD, regfile_we=1, pc_o=0x100, illegal_o=0.
REQ-033 SHALL pass: 5 enqueues with out_ready_i=0, DEPTH=4 -> count_o=4, in_ready_o=0 after the 4th; the 5th is not accepted.
REQ-034 SHALL pass: full queue with simultaneous in_valid_i and out_ready_i -> one dequeue only, count_o=3, FIFO order preserved across wrap after 8 transfers.
REQ-035 SHALL pass: enqueue 0x0000007F -> illegal_o=1, regfile_we=0; 0x00100073 -> ebreak_o=1; 0x40001013 (SLLI, bad imm) -> illegal_o=1.
REQ-036 SHALL pass: flush_i with count_o=3 and in_valid_i=1 -> next cycle count_o=0, out_valid_o=0.
REQ-037 SHALL pass: reset_i asserted between edges with count_o=2 -> count_o=0 and out_valid_o=0 immediately, before the next edge.
